// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU definitions.
// Holds the ALU op-code encoding, the operand-select encodings used by decode
// and issue, and small immediate-extension helpers.
package cpu_pkg;

   // ALU operation codes carried from decode through to the execute stage.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_ADDU = 4'b0001,
      ALU_SUB  = 4'b0010,
      ALU_SUBU = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_LUI  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_SLT  = 4'b1010,
      ALU_SRA  = 4'b1011,
      ALU_SRL  = 4'b1100,
      ALU_SLL  = 4'b1101
   } alu_op_e;

   // Op code loaded into the ID/EX register for a bubble.
   localparam logic [3:0] ALU_BUBBLE = 4'b0000;

   // Operand A select.
   localparam logic       A_SEL_RS    = 1'b0;
   localparam logic       A_SEL_SHAMT = 1'b1;

   // Operand B select.  Both 00 and 11 pick the forwarded rt value.
   localparam logic [1:0] B_SEL_RT    = 2'b00;
   localparam logic [1:0] B_SEL_SEXT  = 2'b01;
   localparam logic [1:0] B_SEL_ZEXT  = 2'b10;
   localparam logic [1:0] B_SEL_RT2   = 2'b11;

   // Sign-extend a 16-bit immediate to 32 bits.
   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   // Zero-extend a 16-bit immediate to 32 bits.
   function automatic logic [31:0] zext16(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel -- operand forwarding selector for one source register.
// Ports:
//   i_src                       source register number being read
//   i_mem_we/i_mem_rd/i_mem_data  EX/MEM forward source
//   i_wb_we/i_wb_rd/i_wb_data     MEM/WB forward source
//   i_reg_data                  register-file read data
//   o_value                     value the instruction should actually see
// The EX/MEM result is newer than MEM/WB, so it wins when both match.
// Register 0 never forwards: a match requires a nonzero destination.
module fwd_sel
   import cpu_pkg::*;
(
   input  logic [4:0]  i_src,
   input  logic        i_mem_we,
   input  logic [4:0]  i_mem_rd,
   input  logic [31:0] i_mem_data,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   input  logic [31:0] i_reg_data,
   output logic [31:0] o_value
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_we && (i_mem_rd != 5'd0) && (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_we  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_src);

   // Priority select: EX/MEM, then MEM/WB, then register file.
   always_comb begin
      o_value = i_reg_data;
      if (w_mem_hit) begin
         o_value = i_mem_data;
      end else if (w_wb_hit) begin
         o_value = i_wb_data;
      end else begin
         o_value = i_reg_data;
      end
   end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue -- ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   id_*                      decoded instruction from the decode stage
//   mem_reg_write/rd/result   EX/MEM forward source
//   wb_reg_write/rd/result    MEM/WB forward source
//   flush                     squash the instruction being issued
//   ex_*                      registered execute-stage controls and operands
//   id_stall                  load-use stall request to fetch/decode
// A bubble (all ex_* zero) is loaded when flush, stall or !id_valid.  The
// stall is derived from the registered EX load, and because the bubble clears
// ex_mem_read the stall naturally lasts a single cycle per hazard.
module id_ex_issue
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        id_valid,
   input  logic [3:0]  id_aluc,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic [4:0]  id_rd_addr,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [15:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic        id_a_sel,
   input  logic [1:0]  id_b_sel,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_result,
   input  logic        flush,
   output logic        ex_valid,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [3:0]  ex_aluc,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic [31:0] ex_store_data,
   output logic        id_stall
);

   logic [31:0] w_rs_fwd;
   logic [31:0] w_rt_fwd;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic        w_stall;
   logic        w_bubble;

   logic        r_valid;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [3:0]  r_aluc;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic        r_mem_read;
   logic [31:0] r_store_data;

   fwd_sel u_fwd_rs (
      .i_src      (id_rs_addr),
      .i_mem_we   (mem_reg_write),
      .i_mem_rd   (mem_rd),
      .i_mem_data (mem_result),
      .i_wb_we    (wb_reg_write),
      .i_wb_rd    (wb_rd),
      .i_wb_data  (wb_result),
      .i_reg_data (id_rs_data),
      .o_value    (w_rs_fwd)
   );

   fwd_sel u_fwd_rt (
      .i_src      (id_rt_addr),
      .i_mem_we   (mem_reg_write),
      .i_mem_rd   (mem_rd),
      .i_mem_data (mem_result),
      .i_wb_we    (wb_reg_write),
      .i_wb_rd    (wb_rd),
      .i_wb_data  (wb_result),
      .i_reg_data (id_rt_data),
      .o_value    (w_rt_fwd)
   );

   // Load in EX whose destination is read by the instruction in decode.
   assign w_stall = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
                    ((id_use_rs && (id_rs_addr == r_rd)) ||
                     (id_use_rt && (id_rt_addr == r_rd)));

   assign w_bubble = flush || w_stall || !id_valid;

   // Operand A/B selection.
   always_comb begin
      w_a = w_rs_fwd;
      w_b = w_rt_fwd;
      if (id_a_sel == A_SEL_SHAMT) begin
         w_a = {27'd0, id_shamt};
      end else begin
         w_a = w_rs_fwd;
      end
      case (id_b_sel)
         B_SEL_RT:   w_b = w_rt_fwd;
         B_SEL_SEXT: w_b = sext16(id_imm);
         B_SEL_ZEXT: w_b = zext16(id_imm);
         B_SEL_RT2:  w_b = w_rt_fwd;
         default:    w_b = w_rt_fwd;
      endcase
   end

   // ID/EX register: issue the decoded instruction or load a bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid      <= 1'b0;
         r_a          <= 32'd0;
         r_b          <= 32'd0;
         r_aluc       <= ALU_BUBBLE;
         r_rd         <= 5'd0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_store_data <= 32'd0;
      end else if (w_bubble) begin
         r_valid      <= 1'b0;
         r_a          <= 32'd0;
         r_b          <= 32'd0;
         r_aluc       <= ALU_BUBBLE;
         r_rd         <= 5'd0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_store_data <= 32'd0;
      end else begin
         r_valid      <= 1'b1;
         r_a          <= w_a;
         r_b          <= w_b;
         r_aluc       <= id_aluc;
         r_rd         <= id_rd_addr;
         r_reg_write  <= id_reg_write;
         r_mem_read   <= id_mem_read;
         r_store_data <= w_rt_fwd;
      end
   end

   assign ex_valid      = r_valid;
   assign ex_a          = r_a;
   assign ex_b          = r_b;
   assign ex_aluc       = r_aluc;
   assign ex_rd         = r_rd;
   // Write/read enables are only ever set together with valid; the AND keeps
   // that true even if the register contents were ever disturbed.
   assign ex_reg_write  = r_reg_write && r_valid;
   assign ex_mem_read   = r_mem_read && r_valid;
   assign ex_store_data = r_store_data;
   assign id_stall      = w_stall;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue -- directed self-checking bench for id_ex_issue.
module tb_id_ex_issue;
   import cpu_pkg::*;

   logic        clk;
   logic        rstn;
   logic        id_valid;
   logic [3:0]  id_aluc;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic [4:0]  id_rd_addr;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [15:0] id_imm;
   logic [4:0]  id_shamt;
   logic        id_a_sel;
   logic [1:0]  id_b_sel;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [3:0]  ex_aluc;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic [31:0] ex_store_data;
   logic        id_stall;

   int errors = 0;
   int checks = 0;

   id_ex_issue dut (
      .clk           (clk),
      .rstn          (rstn),
      .id_valid      (id_valid),
      .id_aluc       (id_aluc),
      .id_rs_addr    (id_rs_addr),
      .id_rt_addr    (id_rt_addr),
      .id_rd_addr    (id_rd_addr),
      .id_rs_data    (id_rs_data),
      .id_rt_data    (id_rt_data),
      .id_imm        (id_imm),
      .id_shamt      (id_shamt),
      .id_a_sel      (id_a_sel),
      .id_b_sel      (id_b_sel),
      .id_use_rs     (id_use_rs),
      .id_use_rt     (id_use_rt),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_aluc       (ex_aluc),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_store_data (ex_store_data),
      .id_stall      (id_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 1'b0; id_aluc = 4'd0; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
      id_rd_addr = 5'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 16'd0;
      id_shamt = 5'd0; id_a_sel = A_SEL_RS; id_b_sel = B_SEL_RT; id_use_rs = 1'b0;
      id_use_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0; flush = 1'b0;
   endtask

   task automatic check_bubble(input string tag);
      check_val({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
      check_val({tag, ".regw"},  {31'd0, ex_reg_write}, 32'd0);
      check_val({tag, ".memr"},  {31'd0, ex_mem_read}, 32'd0);
      check_val({tag, ".aluc"},  {28'd0, ex_aluc}, 32'd0);
      check_val({tag, ".a"},     ex_a, 32'd0);
      check_val({tag, ".b"},     ex_b, 32'd0);
      check_val({tag, ".rd"},    {27'd0, ex_rd}, 32'd0);
      check_val({tag, ".sd"},    ex_store_data, 32'd0);
   endtask

   // Present a lw $9 so that it sits in EX after the next edge.
   task automatic issue_load9();
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_ADD; id_rs_addr = 5'd4; id_rs_data = 32'h0000_1000;
      id_use_rs = 1'b1; id_rd_addr = 5'd9; id_b_sel = B_SEL_SEXT; id_imm = 16'h0004;
      id_reg_write = 1'b1; id_mem_read = 1'b1;
   endtask

   // Dependent instruction reading rt=$9.
   task automatic present_dep9();
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_ADDU; id_rs_addr = 5'd2; id_rs_data = 32'h0000_0002;
      id_rt_addr = 5'd9; id_rt_data = 32'h1111_1111; id_use_rs = 1'b1; id_use_rt = 1'b1;
      id_rd_addr = 5'd10; id_b_sel = B_SEL_RT; id_reg_write = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rstn = 1'b0;

      // Reset state, with an instruction offered that must be discarded.
      id_valid = 1'b1; id_rd_addr = 5'd7; id_reg_write = 1'b1;
      step();
      step();
      check_bubble("reset");
      check_val("reset.stall", {31'd0, id_stall}, 32'd0);
      #2 rstn = 1'b1;

      // addi: rs=5 data 0x10, sign-extended 0xFFFF.
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_ADD; id_rs_addr = 5'd5; id_rs_data = 32'h0000_0010;
      id_use_rs = 1'b1; id_imm = 16'hFFFF; id_b_sel = B_SEL_SEXT; id_rd_addr = 5'd6;
      id_reg_write = 1'b1;
      step();
      check_val("addi.a",     ex_a, 32'h0000_0010);
      check_val("addi.b",     ex_b, 32'hFFFF_FFFF);
      check_val("addi.valid", {31'd0, ex_valid}, 32'd1);
      check_val("addi.rd",    {27'd0, ex_rd}, 32'd6);
      check_val("addi.regw",  {31'd0, ex_reg_write}, 32'd1);
      check_val("addi.aluc",  {28'd0, ex_aluc}, {28'd0, ALU_ADD});

      // Forwarding: both stages match rs=8, EX/MEM wins.
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_OR; id_rs_addr = 5'd8; id_rs_data = 32'h0000_1234;
      id_rt_addr = 5'd3; id_rt_data = 32'h0000_0033; id_use_rs = 1'b1; id_use_rt = 1'b1;
      id_rd_addr = 5'd11; id_reg_write = 1'b1;
      mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'hAAAA_0000;
      wb_reg_write = 1'b1; wb_rd = 5'd8; wb_result = 32'h0000_5555;
      step();
      check_val("fwd.mem_wins", ex_a, 32'hAAAA_0000);
      check_val("fwd.rt_nomatch", ex_b, 32'h0000_0033);

      // Only MEM/WB writing: its value is used.
      mem_reg_write = 1'b0;
      step();
      check_val("fwd.wb", ex_a, 32'h0000_5555);

      // Source 0 with both stages writing register 0: no forwarding.
      id_rs_addr = 5'd0; id_rs_data = 32'hDEAD_0000;
      mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
      step();
      check_val("fwd.r0", ex_a, 32'hDEAD_0000);

      // Store data forwarded from rt while b selects an immediate.
      idle_inputs();
      id_valid = 1'b1; id_rs_addr = 5'd1; id_rs_data = 32'h0000_0100; id_rt_addr = 5'd3;
      id_rt_data = 32'h0000_0033; id_use_rs = 1'b1; id_use_rt = 1'b1; id_b_sel = B_SEL_SEXT;
      id_imm = 16'h0008; wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h7777_0003;
      step();
      check_val("sd.fwd", ex_store_data, 32'h7777_0003);
      check_val("sd.b",   ex_b, 32'h0000_0008);

      // sll shamt 31 with ori imm 0x8000 zero-extended.
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_SLL; id_a_sel = A_SEL_SHAMT; id_shamt = 5'd31;
      id_rs_data = 32'hFFFF_FFFF; id_b_sel = B_SEL_ZEXT; id_imm = 16'h8000;
      id_rd_addr = 5'd12; id_reg_write = 1'b1;
      step();
      check_val("shamt.a", ex_a, 32'h0000_001F);
      check_val("zext.b",  ex_b, 32'h0000_8000);

      // b_sel 11 also picks rt.
      id_a_sel = A_SEL_RS; id_b_sel = B_SEL_RT2; id_rt_data = 32'h0BAD_F00D;
      step();
      check_val("bsel11.b", ex_b, 32'h0BAD_F00D);

      // Load-use: lw $9, then reader of $9.
      issue_load9();
      step();
      check_val("lw.memr", {31'd0, ex_mem_read}, 32'd1);
      check_val("lw.rd",   {27'd0, ex_rd}, 32'd9);
      // Same address but rt not used: no hazard.
      present_dep9();
      id_use_rt = 1'b0;
      #1;
      check_val("lu.no_use", {31'd0, id_stall}, 32'd0);
      present_dep9();
      #1;
      check_val("lu.stall", {31'd0, id_stall}, 32'd1);
      step();
      check_bubble("lu.bubble");
      check_val("lu.stall_once", {31'd0, id_stall}, 32'd0);
      // Reissue: the load is now in MEM and forwards its data.
      mem_reg_write = 1'b1; mem_rd = 5'd9; mem_result = 32'hCAFE_0009;
      step();
      check_val("lu.reissue_valid", {31'd0, ex_valid}, 32'd1);
      check_val("lu.reissue_b", ex_b, 32'hCAFE_0009);
      check_val("lu.reissue_sd", ex_store_data, 32'hCAFE_0009);
      check_val("lu.reissue_rd", {27'd0, ex_rd}, 32'd10);

      // Flush with pending load-use and valid instruction.
      issue_load9();
      step();
      present_dep9();
      flush = 1'b1;
      step();
      check_val("flush.valid", {31'd0, ex_valid}, 32'd0);
      check_val("flush.regw",  {31'd0, ex_reg_write}, 32'd0);

      // Flush alone on a plain valid instruction.
      idle_inputs();
      id_valid = 1'b1; id_rd_addr = 5'd13; id_reg_write = 1'b1; id_rs_data = 32'h55;
      flush = 1'b1;
      step();
      check_bubble("flush2");

      // id_valid low: bubble.
      flush = 1'b0; id_valid = 1'b0;
      step();
      check_bubble("novalid");

      // Asynchronous reset mid-cycle.
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_XOR; id_rs_data = 32'h1234_5678; id_rd_addr = 5'd14;
      id_reg_write = 1'b1; id_mem_read = 1'b1;
      step();
      check_val("pre_rst.valid", {31'd0, ex_valid}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check_bubble("async_rst");
      step();
      check_bubble("rst_hold");
      #2 rstn = 1'b1;
      idle_inputs();
      id_valid = 1'b1; id_aluc = ALU_SUB; id_rs_data = 32'h0000_00AB; id_rt_data = 32'h0000_0001;
      id_rd_addr = 5'd15; id_reg_write = 1'b1;
      step();
      check_val("post_rst.valid", {31'd0, ex_valid}, 32'd1);
      check_val("post_rst.a",     ex_a, 32'h0000_00AB);
      check_val("post_rst.aluc",  {28'd0, ex_aluc}, {28'd0, ALU_SUB});
      check_val("post_rst.rd",    {27'd0, ex_rd}, 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
